// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: carries the fetch prediction and PC+1 through ID/EX,
// resolves BEQ/BNE/JR, drives redirect/flush back to fetch and keeps branch statistics.
module branch_resolve_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic             if_prediction,
  input  logic [31:0]      if_pc1,
  input  logic             stall,
  input  logic [5:0]       ex_opcode,
  input  logic             ex_is_jr,
  input  logic             ex_equal,
  input  logic [31:0]      ex_branch_target,
  input  logic [31:0]      ex_rs_val,
  output logic             BranchSignal,
  output logic             JRSignal,
  output logic             Hit,
  output logic [31:0]      redirect_address,
  output logic             flush,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam logic [5:0]       OP_BEQ  = 6'h04;
  localparam logic [5:0]       OP_BNE  = 6'h05;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             idValid_q, idValid_d;
  logic             idPred_q, idPred_d;
  logic [31:0]      idPc1_q, idPc1_d;
  logic             exValid_q, exValid_d;
  logic             exPred_q, exPred_d;
  logic [31:0]      exPc1_q, exPc1_d;
  logic [CNT_W-1:0] branchCnt_q, branchCnt_d;
  logic [CNT_W-1:0] mispredCnt_q, mispredCnt_d;
  logic             isBranch;
  logic             taken;

  // Resolution is purely combinational so fetch can redirect in the resolving cycle.
  always_comb begin
    isBranch         = (ex_opcode == OP_BEQ) || (ex_opcode == OP_BNE);
    taken            = (ex_opcode == OP_BEQ) ? ex_equal : ~ex_equal;
    BranchSignal     = exValid_q & isBranch;
    JRSignal         = exValid_q & ex_is_jr & ~isBranch;
    Hit              = ~BranchSignal | (taken == exPred_q);
    flush            = JRSignal | (BranchSignal & ~Hit);
    redirect_address = '0;
    if (JRSignal) begin
      redirect_address = ex_rs_val;
    end else if (BranchSignal && !Hit) begin
      redirect_address = taken ? ex_branch_target : exPc1_q;
    end
  end

  always_comb begin
    idValid_d    = idValid_q;
    idPred_d     = idPred_q;
    idPc1_d      = idPc1_q;
    exValid_d    = exValid_q;
    exPred_d     = exPred_q;
    exPc1_d      = exPc1_q;
    branchCnt_d  = branchCnt_q;
    mispredCnt_d = mispredCnt_q;

    // Flush beats stall: both stages empty regardless of the hazard unit.
    if (flush) begin
      idValid_d = 1'b0;
      exValid_d = 1'b0;
    end else if (stall) begin
      exValid_d = 1'b0;
    end else begin
      idValid_d = if_valid;
      idPred_d  = if_prediction;
      idPc1_d   = if_pc1;
      exValid_d = idValid_q;
      exPred_d  = idPred_q;
      exPc1_d   = idPc1_q;
    end

    if (BranchSignal && (branchCnt_q != CNT_MAX)) begin
      branchCnt_d = branchCnt_q + CNT_W'(1);
    end
    if (BranchSignal && !Hit && (mispredCnt_q != CNT_MAX)) begin
      mispredCnt_d = mispredCnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idValid_q    <= 1'b0;
      idPred_q     <= 1'b0;
      idPc1_q      <= '0;
      exValid_q    <= 1'b0;
      exPred_q     <= 1'b0;
      exPc1_q      <= '0;
      branchCnt_q  <= '0;
      mispredCnt_q <= '0;
    end else begin
      idValid_q    <= idValid_d;
      idPred_q     <= idPred_d;
      idPc1_q      <= idPc1_d;
      exValid_q    <= exValid_d;
      exPred_q     <= exPred_d;
      exPc1_q      <= exPc1_d;
      branchCnt_q  <= branchCnt_d;
      mispredCnt_q <= mispredCnt_d;
    end
  end

  assign branch_count     = branchCnt_q;
  assign mispredict_count = mispredCnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: table of single-branch resolutions plus
// hand-written flush, stall, saturation and reset sequences.
module tb_branch_resolve_unit;

  localparam int TB_CNT_W = 4;
  localparam int CNT_SAT  = 15;

  logic                clk;
  logic                rst;
  logic                if_valid;
  logic                if_prediction;
  logic [31:0]         if_pc1;
  logic                stall;
  logic [5:0]          ex_opcode;
  logic                ex_is_jr;
  logic                ex_equal;
  logic [31:0]         ex_branch_target;
  logic [31:0]         ex_rs_val;
  logic                BranchSignal;
  logic                JRSignal;
  logic                Hit;
  logic [31:0]         redirect_address;
  logic                flush;
  logic [TB_CNT_W-1:0] branch_count;
  logic [TB_CNT_W-1:0] mispredict_count;

  branch_resolve_unit #(.CNT_W(TB_CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .if_valid         (if_valid),
    .if_prediction    (if_prediction),
    .if_pc1           (if_pc1),
    .stall            (stall),
    .ex_opcode        (ex_opcode),
    .ex_is_jr         (ex_is_jr),
    .ex_equal         (ex_equal),
    .ex_branch_target (ex_branch_target),
    .ex_rs_val        (ex_rs_val),
    .BranchSignal     (BranchSignal),
    .JRSignal         (JRSignal),
    .Hit              (Hit),
    .redirect_address (redirect_address),
    .flush            (flush),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  typedef struct {
    logic [5:0]  op;
    logic        isJr;
    logic        equal;
    logic        pred;
    logic [31:0] pc1;
    logic [31:0] target;
    logic [31:0] rsVal;
    logic        expBranch;
    logic        expJr;
    logic        expHit;
    logic        expFlush;
    logic [31:0] expRedirect;
  } vec_t;

  localparam int NUM_VECS = 9;
  vec_t vecs[NUM_VECS];
  vec_t v;

  int total;
  int bad;
  int expBr;
  int expMis;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic pred, input logic [31:0] pc1,
                               input logic stl);
    if_valid      = valid;
    if_prediction = pred;
    if_pc1        = pc1;
    stall         = stl;
  endtask

  task automatic setEx(input logic [5:0] op, input logic isJr, input logic eq,
                       input logic [31:0] tgt, input logic [31:0] rs);
    ex_opcode        = op;
    ex_is_jr         = isJr;
    ex_equal         = eq;
    ex_branch_target = tgt;
    ex_rs_val        = rs;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkFlag(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkFlag({tag, ".branch"}, BranchSignal, 1'b0);
    checkFlag({tag, ".jr"}, JRSignal, 1'b0);
    checkFlag({tag, ".hit"}, Hit, 1'b1);
    checkFlag({tag, ".flush"}, flush, 1'b0);
    checkOutput({tag, ".redirect"}, redirect_address, 32'h0);
  endtask

  task automatic checkCounts(input string tag);
    checkOutput({tag, ".branchCount"}, 32'(branch_count), 32'(expBr));
    checkOutput({tag, ".mispredCount"}, 32'(mispredict_count), 32'(expMis));
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    expBr  = 0;
    expMis = 0;

    //           op     jr    eq    pred  pc1       target    rsVal     br    jr    hit   flush redirect
    vecs[0] = '{6'h04, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0,   32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[1] = '{6'h05, 1'b0, 1'b0, 1'b0, 32'h20, 32'h40,  32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 32'h40};
    vecs[2] = '{6'h04, 1'b0, 1'b0, 1'b1, 32'h30, 32'h99,  32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 32'h30};
    vecs[3] = '{6'h00, 1'b1, 1'b0, 1'b0, 32'h44, 32'h0,   32'h1234, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1234};
    vecs[4] = '{6'h05, 1'b0, 1'b0, 1'b1, 32'h50, 32'h70,  32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[5] = '{6'h04, 1'b0, 1'b0, 1'b0, 32'h60, 32'h80,  32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[6] = '{6'h23, 1'b0, 1'b1, 1'b1, 32'h64, 32'h90,  32'h5,    1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[7] = '{6'h04, 1'b1, 1'b1, 1'b0, 32'h68, 32'h500, 32'h777,  1'b1, 1'b0, 1'b0, 1'b1, 32'h500};
    vecs[8] = '{6'h05, 1'b0, 1'b1, 1'b1, 32'h77, 32'h600, 32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 32'h77};

    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    setEx(6'h04, 1'b0, 1'b0, 32'hdead, 32'hbeef);
    step();
    step();
    rst = 1'b1;
    #1;
    checkIdle("reset");
    checkCounts("reset");

    // One instruction at a time: IF -> ID -> EX, checking the empty EX slot first.
    for (int i = 0; i < NUM_VECS; i++) begin
      v = vecs[i];
      applyStimulus(1'b1, v.pred, v.pc1, 1'b0);
      step();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      setEx(v.op, v.isJr, v.equal, v.target, v.rsVal);
      checkIdle($sformatf("vec%0d.empty", i));
      step();
      checkFlag($sformatf("vec%0d.branch", i), BranchSignal, v.expBranch);
      checkFlag($sformatf("vec%0d.jr", i), JRSignal, v.expJr);
      checkFlag($sformatf("vec%0d.hit", i), Hit, v.expHit);
      checkFlag($sformatf("vec%0d.flush", i), flush, v.expFlush);
      checkOutput($sformatf("vec%0d.redirect", i), redirect_address, v.expRedirect);
      step();
      if (v.expBranch) expBr++;
      if (v.expBranch && !v.expHit) expMis++;
      checkCounts($sformatf("vec%0d", i));
    end

    // Mispredicted BEQ flushes the younger instructions in ID and IF.
    applyStimulus(1'b1, 1'b1, 32'h30, 1'b0);
    step();
    setEx(6'h04, 1'b0, 1'b0, 32'h99, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h50, 1'b0);
    step();
    applyStimulus(1'b1, 1'b0, 32'h60, 1'b0);
    checkFlag("flushSeq.flush", flush, 1'b1);
    checkOutput("flushSeq.redirect", redirect_address, 32'h30);
    step();
    expBr++;
    expMis++;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkIdle("flushSeq.killed1");
    step();
    checkIdle("flushSeq.killed2");
    checkCounts("flushSeq");

    // Flush and stall together: flush wins, the ID instruction must not survive.
    applyStimulus(1'b1, 1'b1, 32'h30, 1'b0);
    step();
    applyStimulus(1'b1, 1'b1, 32'h50, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkFlag("flushStall.flush", flush, 1'b1);
    step();
    expBr++;
    expMis++;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkIdle("flushStall.empty1");
    step();
    checkIdle("flushStall.empty2");
    checkCounts("flushStall");

    // Branch held in ID for two stall cycles keeps its own prediction and pc1.
    applyStimulus(1'b1, 1'b1, 32'h88, 1'b0);
    step();
    applyStimulus(1'b1, 1'b0, 32'h99, 1'b1);
    step();
    checkIdle("stall.bubble1");
    step();
    checkIdle("stall.bubble2");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    checkFlag("stall.branch", BranchSignal, 1'b1);
    checkFlag("stall.hit", Hit, 1'b0);
    checkFlag("stall.flush", flush, 1'b1);
    checkOutput("stall.redirect", redirect_address, 32'h88);
    step();
    expBr++;
    expMis++;
    checkCounts("stall");

    // Stream correctly predicted branches until the branch counter saturates.
    setEx(6'h04, 1'b0, 1'b1, 32'h200, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h100, 1'b0);
    repeat (20) step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (3) step();
    expBr = (expBr + 20 > CNT_SAT) ? CNT_SAT : expBr + 20;
    checkCounts("saturate");
    step();
    checkCounts("saturateHold");

    // Reset while a mispredicted branch is resolving discards it uncounted.
    applyStimulus(1'b1, 1'b1, 32'h30, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    setEx(6'h04, 1'b0, 1'b0, 32'h99, 32'h0);
    step();
    checkFlag("midReset.flushBefore", flush, 1'b1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    #1;
    expBr  = 0;
    expMis = 0;
    checkIdle("midReset");
    checkCounts("midReset");
    step();
    checkIdle("midReset.after");
    checkCounts("midReset.after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
